// File: rtl/stripe_scheduler.sv
// Stripe scheduler: walks query stripes through the PE array, streaming the
// reference per stripe and reporting each stripe's end column (natural or early).
module stripe_scheduler (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_job_valid,
    output logic         o_job_ready,
    input  logic [4:0]   i_num_stripes,
    input  logic [9:0]   i_ref_len,
    output logic [3:0]   o_q_addr,
    input  logic [127:0] i_q_data,
    output logic [9:0]   o_r_addr,
    input  logic [1:0]   i_r_data,
    output logic         o_pe_start,
    output logic [1:0]   o_pe_A,
    output logic [127:0] o_pe_B,
    input  logic         i_pe_stripe_end,
    input  logic [9:0]   i_pe_end_position,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [3:0]   o_res_stripe,
    output logic [9:0]   o_res_end,
    output logic         o_res_early,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_REPORT = 3'd6
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [4:0]     num_r;
    logic [9:0]     len_r;
    logic [3:0]     s_r;
    logic [9:0]     cnt_r;
    logic [9:0]     cnt_s;
    logic [127:0]   pe_b_r;
    logic [9:0]     res_end_r;
    logic           res_early_r;
    logic           done_r;
    logic           err_r;
    logic           job_ok_s;
    logic           more_s;

    assign job_ok_s = (i_ref_len != 10'd0) && (i_ref_len <= 10'd960) && (i_num_stripes <= 5'd16);
    assign more_s   = (({1'b0, s_r} + 5'd1) < num_r);

    // Next-state decode; an end pulse only matters while the array is being fed or draining
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_job_valid && job_ok_s && (i_num_stripes != 5'd0)) state_s = ST_FETCH;
                else                                                    state_s = ST_IDLE;
            end
            ST_FETCH: state_s = ST_LOAD;
            ST_LOAD:  state_s = ST_RUN;
            ST_RUN: begin
                if (i_pe_stripe_end)                state_s = ST_FLUSH;
                else if (cnt_r == (len_r - 10'd1))  state_s = ST_DRAIN;
                else                                state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (i_pe_stripe_end)        state_s = ST_FLUSH;
                else if (cnt_r == 10'd63)   state_s = ST_REPORT;
                else                        state_s = ST_DRAIN;
            end
            ST_FLUSH: begin
                if (cnt_r == 10'd63) state_s = ST_REPORT;
                else                 state_s = ST_FLUSH;
            end
            ST_REPORT: begin
                if (i_res_ready && more_s)  state_s = ST_FETCH;
                else if (i_res_ready)       state_s = ST_IDLE;
                else                        state_s = ST_REPORT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-state cycle counter, restarted on every state change
    always_comb begin
        cnt_s = 10'd0;
        if ((state_s == state_r) &&
            ((state_r == ST_RUN) || (state_r == ST_DRAIN) || (state_r == ST_FLUSH))) begin
            cnt_s = cnt_r + 10'd1;
        end else begin
            cnt_s = 10'd0;
        end
    end

    // State, job parameters, query stripe, result and completion registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            num_r       <= 5'd0;
            len_r       <= 10'd0;
            s_r         <= 4'd0;
            cnt_r       <= 10'd0;
            pe_b_r      <= 128'd0;
            res_end_r   <= 10'd0;
            res_early_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_job_valid) begin
                        num_r <= i_num_stripes;
                        len_r <= i_ref_len;
                        s_r   <= 4'd0;
                        if (!job_ok_s) begin
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else if (i_num_stripes == 5'd0) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: pe_b_r <= i_q_data;
                ST_RUN, ST_DRAIN: begin
                    if (i_pe_stripe_end) begin
                        res_end_r   <= i_pe_end_position;
                        res_early_r <= 1'b1;
                    end else if ((state_r == ST_DRAIN) && (cnt_r == 10'd63)) begin
                        res_end_r   <= len_r + 10'd63;
                        res_early_r <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    if (i_res_ready && more_s) begin
                        s_r <= s_r + 4'd1;
                    end else if (i_res_ready) begin
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference address runs one ahead so ref[k] arrives during RUN cycle k
    assign o_job_ready  = (state_r == ST_IDLE);
    assign o_busy       = (state_r != ST_IDLE);
    assign o_q_addr     = s_r;
    assign o_r_addr     = (state_r == ST_RUN) ? (cnt_r + 10'd1) : 10'd0;
    assign o_pe_start   = (state_r == ST_RUN) && !i_pe_stripe_end;
    assign o_pe_A       = (state_r == ST_RUN) ? i_r_data : 2'd0;
    assign o_pe_B       = pe_b_r;
    assign o_res_valid  = (state_r == ST_REPORT);
    assign o_res_stripe = s_r;
    assign o_res_end    = res_end_r;
    assign o_res_early  = res_early_r;
    assign o_done       = done_r;
    assign o_err        = err_r;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Directed bench for stripe_scheduler: normal jobs, early ends in RUN/DRAIN,
// result backpressure, illegal parameters and mid-job reset.
module tb_stripe_scheduler;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_job_valid;
    logic         o_job_ready;
    logic [4:0]   i_num_stripes;
    logic [9:0]   i_ref_len;
    logic [3:0]   o_q_addr;
    logic [127:0] i_q_data;
    logic [9:0]   o_r_addr;
    logic [1:0]   i_r_data;
    logic         o_pe_start;
    logic [1:0]   o_pe_A;
    logic [127:0] o_pe_B;
    logic         i_pe_stripe_end;
    logic [9:0]   i_pe_end_position;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [3:0]   o_res_stripe;
    logic [9:0]   o_res_end;
    logic         o_res_early;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    stripe_scheduler dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
        .i_num_stripes(i_num_stripes), .i_ref_len(i_ref_len),
        .o_q_addr(o_q_addr), .i_q_data(i_q_data),
        .o_r_addr(o_r_addr), .i_r_data(i_r_data),
        .o_pe_start(o_pe_start), .o_pe_A(o_pe_A), .o_pe_B(o_pe_B),
        .i_pe_stripe_end(i_pe_stripe_end), .i_pe_end_position(i_pe_end_position),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_stripe(o_res_stripe), .o_res_end(o_res_end), .o_res_early(o_res_early),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory contents as functions of address
    function automatic logic [1:0] rdat(input logic [9:0] a);
        return a[1:0] ^ a[5:4];
    endfunction
    function automatic logic [127:0] qdat(input logic [3:0] a);
        logic [3:0] v;
        v = a ^ 4'h5;
        return {32{v}};
    endfunction

    // One-cycle-latency query and reference memories
    logic [9:0] r_addr_d;
    logic [3:0] q_addr_d;
    always @(posedge i_clk) begin
        r_addr_d <= o_r_addr;
        q_addr_d <= o_q_addr;
    end
    assign i_r_data = rdat(r_addr_d);
    assign i_q_data = qdat(q_addr_d);

    int n_cmp = 0;
    int n_mis = 0;
    int n_start, max_run, n_res, n_done, err_at_done, pe_bad;
    int res_end_q[4];
    int res_early_q[4];
    int res_stripe_q[4];
    int res_cyc_q[4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic start_job(input logic [4:0] ns, input logic [9:0] rl);
        i_num_stripes = ns;
        i_ref_len     = rl;
        i_job_valid   = 1'b1;
        tick();
        i_job_valid   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, o_job_ready, 1);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_start"}, o_pe_start, 0);
        chk({tag, "_peA"},   o_pe_A, 0);
        chk({tag, "_peB"},   o_pe_B, 0);
        chk({tag, "_qaddr"}, o_q_addr, 0);
        chk({tag, "_raddr"}, o_r_addr, 0);
        chk({tag, "_rvalid"}, o_res_valid, 0);
        chk({tag, "_rstripe"}, o_res_stripe, 0);
        chk({tag, "_rend"},  o_res_end, 0);
        chk({tag, "_rearly"}, o_res_early, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_err"},   o_err, 0);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!o_pe_start && n < 20) begin
            tick();
            n++;
        end
        chk(tag, o_pe_start, 1);
    endtask

    // Run until o_done (or budget), collecting feed and result statistics
    task automatic watch(input int budget, input int base);
        int run_len;
        int k;
        run_len = 0; k = 0;
        n_start = 0; max_run = 0; n_res = 0; n_done = 0; err_at_done = 0; pe_bad = 0;
        for (int c = 0; c < budget && n_done == 0; c++) begin
            tick();
            if (o_pe_start) begin
                if (o_pe_A !== rdat(10'(k)) || o_pe_B !== qdat(4'(base + n_res))) pe_bad++;
                k++; run_len++; n_start++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (o_res_valid && i_res_ready && n_res < 4) begin
                res_end_q[n_res]    = int'(o_res_end);
                res_early_q[n_res]  = int'(o_res_early);
                res_stripe_q[n_res] = int'(o_res_stripe);
                res_cyc_q[n_res]    = c;
                n_res++;
                k = 0;
            end
            if (o_done) begin
                n_done++;
                err_at_done = int'(o_err);
            end
        end
    endtask

    // Called at the negedge where the end pulse is applied; follows FLUSH to REPORT
    task automatic flush_check(input string tag, input logic [9:0] exp_end);
        int n;
        int bad;
        tick();
        i_pe_stripe_end = 1'b0;
        n = 0; bad = 0;
        while (!o_res_valid && n < 200) begin
            if (n == 10) begin
                i_pe_stripe_end   = 1'b1;
                i_pe_end_position = 10'd999;
                i_job_valid       = 1'b1;
                i_num_stripes     = 5'd0;
            end else begin
                i_pe_stripe_end = 1'b0;
                i_job_valid     = 1'b0;
            end
            tick();
            n++;
            if (o_pe_start || o_done || !o_busy) bad++;
        end
        i_pe_stripe_end = 1'b0;
        i_job_valid     = 1'b0;
        chk({tag, "_flush_len"}, n, 64);
        chk({tag, "_flush_quiet"}, bad, 0);
        chk({tag, "_end"}, o_res_end, exp_end);
        chk({tag, "_early"}, o_res_early, 1);
        chk({tag, "_stripe"}, o_res_stripe, 0);
        tick();
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_done_err"}, o_err, 0);
    endtask

    task automatic bad_job(input string tag, input logic [4:0] ns, input logic [9:0] rl, input logic exp_err);
        i_num_stripes = ns;
        i_ref_len     = rl;
        i_job_valid   = 1'b1;
        tick();
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_err"}, o_err, exp_err);
        chk({tag, "_idle"}, o_job_ready, 1);
        chk({tag, "_nostart"}, o_pe_start, 0);
        i_job_valid = 1'b0;
        tick();
        chk({tag, "_done_clr"}, o_done, 0);
        chk({tag, "_nostart2"}, o_pe_start, 0);
    endtask

    initial begin
        int n;
        int bad;
        i_rst_n = 1'b0; i_job_valid = 1'b0; i_num_stripes = 5'd0; i_ref_len = 10'd0;
        i_pe_stripe_end = 1'b0; i_pe_end_position = 10'd0; i_res_ready = 1'b1;
        tick(); tick();
        chk_reset("rst");
        i_rst_n = 1'b1;
        tick();

        // Two stripes, ref_len 5, no backpressure
        start_job(5'd2, 10'd5);
        chk("fetch_busy", o_busy, 1);
        chk("fetch_notready", o_job_ready, 0);
        chk("fetch_qaddr", o_q_addr, 0);
        watch(400, 0);
        chk("n2_results", n_res, 2);
        chk("n2_end0", res_end_q[0], 68);
        chk("n2_end1", res_end_q[1], 68);
        chk("n2_early0", res_early_q[0], 0);
        chk("n2_early1", res_early_q[1], 0);
        chk("n2_stripe1", res_stripe_q[1], 1);
        chk("n2_starts", n_start, 10);
        chk("n2_maxrun", max_run, 5);
        chk("n2_period", res_cyc_q[1] - res_cyc_q[0], 72);
        chk("n2_pe_data", pe_bad, 0);
        chk("n2_done", n_done, 1);
        chk("n2_done_err", err_at_done, 0);

        // Early end in RUN k=40
        tick();
        start_job(5'd1, 10'd100);
        wait_start("run_early_start");
        repeat (40) tick();
        i_pe_stripe_end = 1'b1; i_pe_end_position = 10'd40;
        #1;
        chk("run_early_gate", o_pe_start, 0);
        flush_check("run_early", 10'd40);

        // Early end in DRAIN cycle 10
        tick();
        start_job(5'd1, 10'd100);
        wait_start("drain_early_start");
        repeat (110) tick();
        chk("drain_in_drain", o_busy, 1);
        i_pe_stripe_end = 1'b1; i_pe_end_position = 10'd110;
        #1;
        chk("drain_early_gate", o_pe_start, 0);
        flush_check("drain_early", 10'd110);

        // Result backpressure for 20 cycles
        tick();
        i_res_ready = 1'b0;
        start_job(5'd2, 10'd1);
        n = 0;
        while (!o_res_valid && n < 200) begin
            tick();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (!(o_res_valid && o_res_stripe == 4'd0 && o_res_end == 10'd64 && !o_res_early)) bad++;
            tick();
        end
        if (!(o_res_valid && o_res_stripe == 4'd0 && o_res_end == 10'd64 && !o_res_early)) bad++;
        chk("bp_stable", bad, 0);
        i_res_ready = 1'b1;
        tick();
        chk("bp_released", o_res_valid, 0);
        chk("bp_next_qaddr", o_q_addr, 1);
        chk("bp_busy", o_busy, 1);
        watch(200, 1);
        chk("bp_results", n_res, 1);
        chk("bp_end", res_end_q[0], 64);
        chk("bp_stripe", res_stripe_q[0], 1);
        chk("bp_pe_data", pe_bad, 0);
        chk("bp_done", n_done, 1);

        // Illegal and empty jobs
        tick();
        bad_job("len0", 5'd1, 10'd0, 1'b1);
        bad_job("len961", 5'd1, 10'd961, 1'b1);
        bad_job("ns17", 5'd17, 10'd5, 1'b1);
        bad_job("ns0", 5'd0, 10'd5, 1'b0);

        // Reset at RUN k=3, then a fresh job
        start_job(5'd2, 10'd5);
        wait_start("rstmid_start");
        repeat (3) tick();
        i_rst_n = 1'b0;
        tick();
        chk_reset("rstmid");
        i_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_done || o_pe_start || o_busy) bad++;
        end
        chk("rstmid_quiet", bad, 0);
        start_job(5'd1, 10'd3);
        watch(200, 0);
        chk("post_rst_results", n_res, 1);
        chk("post_rst_end", res_end_q[0], 66);
        chk("post_rst_starts", n_start, 3);
        chk("post_rst_pe_data", pe_bad, 0);
        chk("post_rst_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stripe_scheduler.md
STRIPE_SCHEDULER -- requirements
Module: stripe_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; i_clk and i_rst_n are the only clock and reset ports.
REQ-002 i_clk  in  1  rising-edge clock.
REQ-003 i_rst_n  in  1  synchronous active-low reset.
REQ-004 i_job_valid / o_job_ready  in/out  1/1  job handshake; a job is accepted on a cycle with both high.
REQ-005 i_num_stripes  in  5  number of 64-base query stripes, 0..16.
REQ-006 i_ref_len  in  10  reference length in bases; legal range 1..960.
REQ-007 o_q_addr  out  4  query memory stripe address; i_q_data  in  128  data, valid 1 cycle after address.
REQ-008 o_r_addr  out  10  reference memory base address; i_r_data  in  2  data, valid 1 cycle after address.
REQ-009 o_pe_start  out  1  PE array start/feed enable; o_pe_A  out  2  reference base; o_pe_B  out  128  query stripe.
REQ-010 i_pe_stripe_end  in  1  early-termination pulse from the array; i_pe_end_position  in  10  its column.
REQ-011 o_res_valid / i_res_ready  out/in  1/1  result handshake; o_res_stripe  out  4; o_res_end  out  10; o_res_early  out  1.
REQ-012 o_busy  out  1  job in progress; o_done  out  1  one-cycle job-complete pulse; o_err  out  1  valid only with o_done.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, LOAD, RUN, DRAIN, FLUSH, REPORT; o_job_ready = 1 only in IDLE.
REQ-014 On accept, i_num_stripes and i_ref_len SHALL be latched, the stripe index s cleared, and the next state SHALL be FETCH.
REQ-015 On accept with i_ref_len = 0, i_ref_len > 960, or i_num_stripes > 16, the block SHALL pulse o_done with o_err = 1 next cycle and stay IDLE.
REQ-016 On accept with i_num_stripes = 0 and legal ref_len, the block SHALL pulse o_done with o_err = 0 next cycle and issue no o_pe_start.
REQ-017 FETCH (1 cycle): o_q_addr = s, o_r_addr = 0.
REQ-018 LOAD (1 cycle): o_r_addr = 0; o_pe_B SHALL load i_q_data at the end of this cycle and hold it until the next LOAD.
REQ-019 RUN cycle k (k = 0..ref_len-1): raw start = 1, o_pe_A = i_r_data (= ref[k]), o_r_addr = k+1; after ref_len cycles, go to DRAIN.
REQ-020 o_pe_start SHALL equal raw start AND NOT i_pe_stripe_end, so the array never restarts on its end pulse.
REQ-021 DRAIN: raw start = 0 for 64 cycles, then REPORT with o_res_end = ref_len + 63 and o_res_early = 0.
REQ-022 i_pe_stripe_end = 1 in RUN or DRAIN SHALL latch o_res_end = i_pe_end_position and o_res_early = 1, then go to FLUSH.
REQ-023 FLUSH: raw start = 0 for exactly 64 cycles so the array enable pipeline empties, then REPORT.
REQ-024 i_pe_stripe_end SHALL be ignored in IDLE, FETCH, LOAD, FLUSH and REPORT.
REQ-025 REPORT: o_res_valid = 1 and o_res_stripe = s; o_res_stripe, o_res_end and o_res_early SHALL stay stable until i_res_ready.
REQ-026 When the result handshake completes, the FSM SHALL go to FETCH with s+1 if s+1 < num_stripes, else pulse o_done (o_err = 0) and return to IDLE.
REQ-027 Stripe period with no backpressure and no early end SHALL be 1 + 1 + ref_len + 64 + 1 cycles.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 Counters SHALL be 10-bit unsigned and SHALL not wrap within legal ranges, since ref_len + 63 <= 1023.
REQ-030 i_job_valid outside IDLE SHALL have no effect.

Reset
REQ-031 With i_rst_n low at a clock edge, the next cycle SHALL show: state IDLE, s = 0, o_pe_start = 0, o_pe_A = 0, o_pe_B = 0, o_q_addr = 0, o_r_addr = 0, o_res_valid = 0, o_res_stripe = 0, o_res_end = 0, o_res_early = 0, o_busy = 0, o_done = 0, o_err = 0, o_job_ready = 1.
REQ-032 Reset asserted mid-job (any state) SHALL abandon the job with no o_done and no further o_pe_start.

Verification
REQ-033 Job {num_stripes = 2, ref_len = 5}, i_res_ready = 1, no early end -> two results, o_res_end = 68 and o_res_early = 0 for each; o_pe_start high 5 consecutive cycles per stripe; stripe period 72 cycles; one o_done.
REQ-034 ref_len = 100, i_pe_stripe_end at RUN k = 40 with position 40 -> o_pe_start low that same cycle, 64 FLUSH cycles, result {end = 40, early = 1}.
REQ-035 Early end in DRAIN cycle 10 with position 110 (ref_len = 100) -> FLUSH 64 cycles, result {end = 110, early = 1}.
REQ-036 i_res_ready held low 20 cycles in REPORT -> o_res_valid and result fields stable for those 20 cycles; next FETCH one cycle after ready.
REQ-037 Jobs with ref_len = 0, ref_len = 961, num_stripes = 17 -> o_done = o_err = 1 next cycle, no o_pe_start; num_stripes = 0 -> o_done with o_err = 0.
REQ-038 Reset asserted at RUN k = 3 -> the REQ-031 output values the next cycle, and a new job then runs normally.
